// File: rtl/conv3x3_engine.sv
// Row-parallel 3x3 / 1x1 convolution engine: buffers one row beat at a time, MACs it into
// CONV_UNITS accumulators, then adds bias, saturates and streams the block out serially.
module conv3x3_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int CONV_UNITS = 8,
    parameter int FRAC_BITS  = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 l_valid,
    output logic                                 l_rdy,
    input  logic [DATA_WIDTH*(CONV_UNITS+2)-1:0] x_in,
    input  logic [DATA_WIDTH-1:0]                K1,
    input  logic [DATA_WIDTH-1:0]                K2,
    input  logic [DATA_WIDTH-1:0]                K3,
    input  logic [DATA_WIDTH-1:0]                K4,
    input  logic [DATA_WIDTH-1:0]                K5,
    input  logic [DATA_WIDTH-1:0]                K6,
    input  logic [DATA_WIDTH-1:0]                K7,
    input  logic [DATA_WIDTH-1:0]                K8,
    input  logic [DATA_WIDTH-1:0]                K9,
    input  logic [DATA_WIDTH-1:0]                bias,
    input  logic [31:0]                          ch_in,
    input  logic [31:0]                          im_width,
    input  logic [31:0]                          num_blocks,
    input  logic                                 mode,
    output logic                                 r_valid,
    input  logic                                 r_rdy,
    output logic [DATA_WIDTH-1:0]                T_out,
    output logic                                 finished
);

    localparam int LANES = CONV_UNITS + 2;
    localparam int AW    = 2 * DATA_WIDTH + 8;
    localparam int WCW   = (CONV_UNITS > 1) ? $clog2(CONV_UNITS) : 1;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StAccum, StFlush, StFin, StOut, StDone} state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] x_q [LANES];
    logic signed [DATA_WIDTH-1:0] k_q [9];
    logic signed [DATA_WIDTH-1:0] bias_q;
    logic [1:0]                   row_q, buf_row_q;
    logic                         buf_mode_q, mac_en_q;
    logic [33:0]                  beat_cnt_q;
    logic                         mode_q;
    logic [31:0]                  ch_q;
    logic [31:0]                  block_cnt_q;
    logic [WCW-1:0]               word_cnt_q;
    logic signed [AW-1:0]         acc_q [CONV_UNITS];
    logic signed [DATA_WIDTH-1:0] out_q [CONV_UNITS];

    logic                         accept, take;
    logic                         first_beat, mode_eff, last_beat, last_word, last_block;
    logic [31:0]                  ch_raw, ch_eff, nb_eff;
    logic [33:0]                  beats_blk;
    logic [32:0]                  block_next;
    logic signed [DATA_WIDTH-1:0] kr [3];
    logic signed [AW-1:0]         mac_sum [CONV_UNITS];
    logic signed [DATA_WIDTH-1:0] fin [CONV_UNITS];

    logic unused_im_width;
    assign unused_im_width = ^im_width;

    // mode/ch_in take effect from the first beat of a block and are held for the rest of it
    always_comb begin
        first_beat = (beat_cnt_q == 34'd0);
        mode_eff   = first_beat ? mode : mode_q;
        ch_raw     = first_beat ? ch_in : ch_q;
        ch_eff     = (ch_raw == 32'd0) ? 32'd1 : ch_raw;
        beats_blk  = mode_eff ? {2'b00, ch_eff} : ({2'b00, ch_eff} + {1'b0, ch_eff, 1'b0});
        last_beat  = (beat_cnt_q == beats_blk - 34'd1);
        nb_eff     = (num_blocks == 32'd0) ? 32'd1 : num_blocks;
        block_next = {1'b0, block_cnt_q} + 33'd1;
        last_block = (block_next == {1'b0, nb_eff});
        last_word  = (word_cnt_q == WCW'(CONV_UNITS - 1));
    end

    always_comb begin
        state_d  = state_q;
        l_rdy    = 1'b0;
        r_valid  = 1'b0;
        finished = 1'b0;
        accept   = 1'b0;
        take     = 1'b0;
        unique case (state_q)
            StIdle:  state_d = StAccum;
            StAccum: begin
                l_rdy  = 1'b1;
                accept = l_valid;
                if (l_valid && last_beat) state_d = StFlush;
            end
            StFlush: state_d = StFin;
            StFin:   state_d = StOut;
            StOut: begin
                r_valid = 1'b1;
                take    = r_rdy;
                if (r_rdy && last_word) state_d = last_block ? StDone : StAccum;
            end
            StDone: begin
                finished = 1'b1;
                state_d  = StAccum;
            end
            default: state_d = StIdle;
        endcase
    end

    // 1x1 mode reuses the 3-tap datapath with only the centre tap populated
    always_comb begin
        logic signed [2*DATA_WIDTH-1:0] prod;
        prod = '0;
        if (buf_mode_q) begin
            kr[0] = '0;
            kr[1] = k_q[4];
            kr[2] = '0;
        end else begin
            unique case (buf_row_q)
                2'd0:    for (int j = 0; j < 3; j++) kr[j] = k_q[j];
                2'd1:    for (int j = 0; j < 3; j++) kr[j] = k_q[3+j];
                default: for (int j = 0; j < 3; j++) kr[j] = k_q[6+j];
            endcase
        end
        for (int i = 0; i < CONV_UNITS; i++) begin
            mac_sum[i] = '0;
            for (int j = 0; j < 3; j++) begin
                prod       = kr[j] * x_q[i+j];
                mac_sum[i] = mac_sum[i] + {{(AW-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
            end
        end
    end

    always_comb begin
        logic signed [AW-1:0] bias_sh, v;
        bias_sh = {{(AW-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
        bias_sh = bias_sh <<< FRAC_BITS;
        v       = '0;
        for (int i = 0; i < CONV_UNITS; i++) begin
            v = acc_q[i] + bias_sh;
            v = v >>> FRAC_BITS;
            if (v > SAT_MAX)      fin[i] = SAT_MAX[DATA_WIDTH-1:0];
            else if (v < SAT_MIN) fin[i] = SAT_MIN[DATA_WIDTH-1:0];
            else                  fin[i] = v[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < LANES; n++) x_q[n] <= '0;
            for (int n = 0; n < 9; n++) k_q[n] <= '0;
            bias_q      <= '0;
            row_q       <= '0;
            buf_row_q   <= '0;
            buf_mode_q  <= 1'b0;
            mac_en_q    <= 1'b0;
            beat_cnt_q  <= '0;
            mode_q      <= 1'b0;
            ch_q        <= '0;
            block_cnt_q <= '0;
            word_cnt_q  <= '0;
            for (int i = 0; i < CONV_UNITS; i++) begin
                acc_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            mac_en_q <= accept;
            if (accept) begin
                for (int n = 0; n < LANES; n++) x_q[n] <= x_in[DATA_WIDTH*n +: DATA_WIDTH];
                k_q[0]     <= K1;
                k_q[1]     <= K2;
                k_q[2]     <= K3;
                k_q[3]     <= K4;
                k_q[4]     <= K5;
                k_q[5]     <= K6;
                k_q[6]     <= K7;
                k_q[7]     <= K8;
                k_q[8]     <= K9;
                bias_q     <= bias;
                buf_row_q  <= row_q;
                buf_mode_q <= mode_eff;
                if (first_beat) begin
                    mode_q <= mode;
                    ch_q   <= ch_in;
                end
            end

            if (state_q == StIdle) begin
                beat_cnt_q <= '0;
                row_q      <= '0;
            end else if (accept) begin
                beat_cnt_q <= last_beat ? 34'd0 : beat_cnt_q + 34'd1;
                row_q      <= (last_beat || row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
            end

            if (state_q == StIdle || state_q == StDone) begin
                block_cnt_q <= '0;
            end else if (take && last_word) begin
                block_cnt_q <= block_next[31:0];
            end

            for (int i = 0; i < CONV_UNITS; i++) begin
                if (state_q == StFin)  acc_q[i] <= '0;
                else if (mac_en_q)     acc_q[i] <= acc_q[i] + mac_sum[i];
            end

            if (state_q == StFin) begin
                for (int i = 0; i < CONV_UNITS; i++) out_q[i] <= fin[i];
                word_cnt_q <= '0;
            end else if (take) begin
                for (int i = 0; i < CONV_UNITS - 1; i++) out_q[i] <= out_q[i+1];
                out_q[CONV_UNITS-1] <= '0;
                word_cnt_q          <= word_cnt_q + WCW'(1);
            end
        end
    end

    assign T_out = out_q[0];

endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed bench for conv3x3_engine: reset abort, 1x1 and 3x3 blocks, row selection,
// saturation and a two-block job under random input gaps and output backpressure.
module tb_conv3x3_engine;

    localparam int DW    = 16;
    localparam int CU    = 8;
    localparam int LANES = CU + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              l_valid = 1'b0;
    logic              r_rdy = 1'b1;
    logic              mode = 1'b0;
    logic              l_rdy, r_valid, finished;
    logic [DW-1:0]     T_out;
    logic [DW*LANES-1:0] x_in = '0;
    logic [DW-1:0]     k_drv [9];
    logic [DW-1:0]     bias_drv = '0;
    logic [31:0]       ch_in = 32'd1;
    logic [31:0]       im_width = 32'd0;
    logic [31:0]       num_blocks = 32'd1;

    int lanes [LANES];
    int kw [9];
    int got [$];
    int exp_q [$];
    int n_checks = 0;
    int n_fail = 0;
    int fin_cnt = 0;
    int fin_words = -1;
    bit bp_on = 1'b0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_t = '0;

    conv3x3_engine #(.DATA_WIDTH(DW), .CONV_UNITS(CU), .FRAC_BITS(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .l_valid    (l_valid),
        .l_rdy      (l_rdy),
        .x_in       (x_in),
        .K1         (k_drv[0]),
        .K2         (k_drv[1]),
        .K3         (k_drv[2]),
        .K4         (k_drv[3]),
        .K5         (k_drv[4]),
        .K6         (k_drv[5]),
        .K7         (k_drv[6]),
        .K8         (k_drv[7]),
        .K9         (k_drv[8]),
        .bias       (bias_drv),
        .ch_in      (ch_in),
        .im_width   (im_width),
        .num_blocks (num_blocks),
        .mode       (mode),
        .r_valid    (r_valid),
        .r_rdy      (r_rdy),
        .T_out      (T_out),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        r_rdy = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor on the falling edge, clear of the active edge
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", r_valid, 1);
                check("stall_hold", $signed(T_out), $signed(prev_t));
            end
            if (finished) begin
                fin_cnt++;
                fin_words = got.size();
            end
            if (r_valid && r_rdy) got.push_back(int'($signed(T_out)));
            prev_stall = r_valid && !r_rdy;
            prev_t     = T_out;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_sb();
        got.delete();
        exp_q.delete();
        fin_cnt   = 0;
        fin_words = -1;
    endtask

    task automatic set_lanes_ramp(input int base, input int step);
        for (int n = 0; n < LANES; n++) lanes[n] = base + step * n;
    endtask

    task automatic set_lanes_const(input int v);
        for (int n = 0; n < LANES; n++) lanes[n] = v;
    endtask

    task automatic set_k_all(input int v);
        for (int j = 0; j < 9; j++) kw[j] = v;
    endtask

    // Returns #1 after the accepting edge with l_valid dropped
    task automatic send_beat(input int b);
        int guard;
        for (int n = 0; n < LANES; n++) x_in[DW*n +: DW] = lanes[n][DW-1:0];
        for (int j = 0; j < 9; j++) k_drv[j] = kw[j][DW-1:0];
        bias_drv = b[DW-1:0];
        l_valid  = 1'b1;
        guard    = 0;
        while (!l_rdy) begin
            tick();
            guard++;
            if (guard > 200) begin
                check("beat_timeout", 0, 1);
                l_valid = 1'b0;
                return;
            end
        end
        tick();
        l_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int guard;
        guard = 0;
        while (got.size() < n) begin
            tick();
            guard++;
            if (guard > 500) begin
                check("word_timeout", got.size(), n);
                return;
            end
        end
    endtask

    task automatic check_words(input string tag);
        wait_words(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < got.size()) ? got[i] : -999999, exp_q[i]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_l_rdy"}, l_rdy, 0);
        check({tag, "_r_valid"}, r_valid, 0);
        check({tag, "_t_out"}, T_out, 0);
        check({tag, "_finished"}, finished, 0);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
        check("rel_idle_l_rdy", l_rdy, 0);
        tick();
        check("rel_accum_l_rdy", l_rdy, 1);
    endtask

    task automatic check_job_end(input string tag, input int words);
        tick(3);
        check({tag, "_fin_cnt"}, fin_cnt, 1);
        check({tag, "_fin_words"}, fin_words, words);
        check({tag, "_l_rdy_next"}, l_rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d words", got.size());
        $fatal(1);
    end

    initial begin
        for (int j = 0; j < 9; j++) k_drv[j] = '0;
        set_k_all(0);
        set_lanes_const(0);

        // Power-on reset, then abort a partially accumulated 3x3 block
        tick(2);
        check_outputs_zero("por");
        release_reset();
        mode = 1'b0;
        ch_in = 32'd1;
        set_lanes_const(1);
        set_k_all(1);
        send_beat(0);
        send_beat(0);
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        tick(2);
        release_reset();
        tick(10);
        check("abort_no_valid", r_valid, 0);
        check("abort_no_words", got.size(), 0);

        // 1x1, lanes 1..10, K5=2, bias 3, with output latency
        clear_sb();
        mode = 1'b1;
        set_lanes_ramp(1, 1);
        set_k_all(0);
        kw[4] = 2;
        send_beat(3);
        check("lat_e0_l_rdy", l_rdy, 0);
        check("lat_e0_r_valid", r_valid, 0);
        tick();
        check("lat_e1_r_valid", r_valid, 0);
        tick();
        check("lat_e2_r_valid", r_valid, 1);
        check("lat_e2_t_out", $signed(T_out), 7);
        for (int i = 0; i < CU; i++) exp_q.push_back(7 + 2 * i);
        check_words("m1_word");
        check_job_end("m1", 8);

        // 3x3, one channel, all ones
        clear_sb();
        mode = 1'b0;
        set_lanes_const(1);
        set_k_all(1);
        repeat (3) send_beat(0);
        check("m0_l_rdy_after", l_rdy, 0);
        for (int i = 0; i < CU; i++) exp_q.push_back(9);
        check_words("m0_word");
        check_job_end("m0", 8);

        // 3x3, three channels, bias -5 on the last beat
        clear_sb();
        ch_in = 32'd3;
        for (int b = 0; b < 9; b++) send_beat((b == 8) ? -5 : 0);
        for (int i = 0; i < CU; i++) exp_q.push_back(22);
        check_words("ch3_word");
        check_job_end("ch3", 8);

        // Row selection: only the current kernel row counts; zero row contributes nothing
        clear_sb();
        ch_in = 32'd1;
        set_lanes_ramp(0, 1);
        kw = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        send_beat(0);
        kw = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        send_beat(0);
        kw = '{0, 0, 0, 0, 0, 0, 2, 2, 2};
        send_beat(0);
        for (int i = 0; i < CU; i++) exp_q.push_back(9 * i + 9);
        check_words("row_word");
        check_job_end("row", 8);

        // Saturation at both rails
        clear_sb();
        mode = 1'b1;
        set_k_all(32767);
        set_lanes_const(32767);
        send_beat(0);
        for (int i = 0; i < CU; i++) exp_q.push_back(32767);
        check_words("sat_hi");
        check_job_end("sat_hi", 8);
        clear_sb();
        set_lanes_const(-32768);
        send_beat(0);
        for (int i = 0; i < CU; i++) exp_q.push_back(-32768);
        check_words("sat_lo");
        check_job_end("sat_lo", 8);

        // Two-block job with input gaps, output backpressure and mid-block mode/ch_in changes
        clear_sb();
        num_blocks = 32'd2;
        ch_in = 32'd2;
        mode = 1'b1;
        bp_on = 1'b1;
        set_k_all(0);
        set_lanes_ramp(0, 1);
        kw[4] = 1;
        tick($urandom_range(0, 3));
        send_beat(50);
        mode = 1'b0;
        ch_in = 32'd7;
        set_lanes_const(10);
        kw[4] = 3;
        tick($urandom_range(0, 3));
        send_beat(1);
        mode = 1'b1;
        ch_in = 32'd2;
        set_lanes_ramp(0, -1);
        kw[4] = 1;
        tick($urandom_range(0, 3));
        send_beat(0);
        set_lanes_const(0);
        kw[4] = 9;
        tick($urandom_range(0, 3));
        send_beat(100);
        for (int i = 0; i < CU; i++) exp_q.push_back(32 + i);
        for (int i = 0; i < CU; i++) exp_q.push_back(99 - i);
        check_words("bp_word");
        bp_on = 1'b0;
        check_job_end("bp", 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
